// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB-first,
// odd parity and stop, then device acknowledge check. Pins are driven through open-drain enables.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned INHIBIT_CYCLES = 10_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_oe,
    output logic       kb_data_oe,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_ACK
    } state_t;

    state_t           r_state, w_state_next;
    logic [2:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic [9:0]       r_shift, w_shift_next;
    logic [3:0]       r_edge_cnt, w_edge_cnt_next;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
    logic [WD_W-1:0]  r_wd_cnt, w_wd_cnt_next;
    logic             r_clk_oe, w_clk_oe_next;
    logic             r_data_oe, w_data_oe_next;
    logic             r_ready, w_ready_next;
    logic             r_done, w_done_next;
    logic             r_err, w_err_next;
    logic             w_fall, w_timeout, w_accept;

    // Third clock flop gives the previous synced level for fall detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], kb_clk_in};
            r_data_sync <= {r_data_sync[0], kb_data_in};
        end
    end

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_timeout = (r_wd_cnt == WD_LAST);
    assign w_accept  = tx_valid & r_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_edge_cnt <= '0;
            r_inh_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_inh_cnt  <= w_inh_cnt_next;
            r_wd_cnt   <= w_wd_cnt_next;
            r_clk_oe   <= w_clk_oe_next;
            r_data_oe  <= w_data_oe_next;
            r_ready    <= w_ready_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_edge_cnt_next = r_edge_cnt;
        w_inh_cnt_next  = r_inh_cnt;
        w_wd_cnt_next   = r_wd_cnt;
        w_data_oe_next  = r_data_oe;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_data_oe_next = 1'b0;
                if (w_accept) begin
                    w_shift_next    = {1'b1, ~^tx_data, tx_data};
                    w_edge_cnt_next = '0;
                    w_inh_cnt_next  = '0;
                    w_state_next    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_next   = S_RTS;
                    w_data_oe_next = 1'b1;
                    w_wd_cnt_next  = '0;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + 1'b1;
                end
            end
            S_RTS, S_DATA, S_ACK: begin
                w_wd_cnt_next = r_wd_cnt + 1'b1;
                // A fall-11 acknowledge outranks a coincident watchdog expiry.
                if (r_state == S_ACK && w_fall) begin
                    w_done_next    = ~r_data_sync[1];
                    w_err_next     = r_data_sync[1];
                    w_data_oe_next = 1'b0;
                    w_state_next   = S_IDLE;
                end else if (w_timeout) begin
                    w_err_next     = 1'b1;
                    w_data_oe_next = 1'b0;
                    w_state_next   = S_IDLE;
                end else if (w_fall && r_state != S_ACK) begin
                    // Falls 1..10 present d0..d7, parity, then the stop bit (a release).
                    w_data_oe_next  = ~r_shift[0];
                    w_shift_next    = {1'b1, r_shift[9:1]};
                    w_edge_cnt_next = r_edge_cnt + 4'd1;
                    if (r_state == S_RTS) begin
                        w_state_next = S_DATA;
                    end else if (r_edge_cnt == 4'd9) begin
                        w_state_next = S_ACK;
                    end
                end
            end
            default: begin
                w_data_oe_next = 1'b0;
                w_state_next   = S_IDLE;
            end
        endcase

        w_clk_oe_next = (w_state_next == S_INHIBIT);
        w_ready_next  = (w_state_next == S_IDLE);
    end

    assign tx_ready   = r_ready;
    assign kb_clk_oe  = r_clk_oe;
    assign kb_data_oe = r_data_oe;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a simple PS/2 device model clocks frames out of the host
// and records the data pin level on every low phase.
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kb_clk_oe, kb_data_oe, tx_done, tx_err;
    logic       kb_clk_in, kb_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign kb_clk_in  = dev_clk & ~kb_clk_oe;
    assign kb_data_in = dev_data & ~kb_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ   (100_000_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .kb_clk_in (kb_clk_in),
        .kb_data_in(kb_data_in),
        .kb_clk_oe (kb_clk_oe),
        .kb_data_oe(kb_data_oe),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_err = 0;
    int n_ready_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        if ((tx_done || tx_err) && !tx_ready) n_ready_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack, input int nfalls,
                            output logic [9:0] bits, output int inh_len, output bit rts_ok);
        int w;
        bits = '0;
        w = 0;
        while (!tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        inh_len = 0;
        while (kb_clk_oe && inh_len < 200) begin
            inh_len++;
            @(negedge clk);
        end
        rts_ok = kb_data_oe && !kb_clk_oe;
        repeat (5) @(negedge clk);
        for (int f = 1; f <= nfalls; f++) begin
            if (f == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (f <= 10) bits[f-1] = kb_data_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_bits;   // {stop, parity, d7..d0} as seen on falls 10..1
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0] bits;
        int         inh_len;
        bit         rts_ok;
        int         d0, e0, w, rts_cyc, err_at;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 10'h300, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 10'h201, 1, 0};
        vecs[4] = '{8'hA5, 1'b0, 10'h3A5, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_clk_oe", 32'(kb_clk_oe), 32'd0);
        chk("reset_data_oe", 32'(kb_data_oe), 32'd0);
        chk("reset_pulses", 32'(tx_done | tx_err), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d0 = n_done;
            e0 = n_err;
            do_frame(vecs[i].data, vecs[i].ack, 11, bits, inh_len, rts_ok);
            repeat (10) @(negedge clk);
            $display("frame %02h ack=%0d inhibit=%0d bits=%03h done=%0d err=%0d",
                     vecs[i].data, vecs[i].ack, inh_len, bits, n_done - d0, n_err - e0);
            chk("inhibit_len", 32'(inh_len), 32'(INH));
            chk("rts_after_inhibit", 32'(rts_ok), 32'd1);
            chk("frame_bits", 32'(bits), 32'(vecs[i].exp_bits));
            chk("done_count", 32'(n_done - d0), 32'(vecs[i].exp_done));
            chk("err_count", 32'(n_err - e0), 32'(vecs[i].exp_err));
            chk("end_lines", {30'd0, kb_clk_oe, kb_data_oe}, 32'd0);
            chk("end_ready", 32'(tx_ready), 32'd1);
        end

        // Silent device: watchdog must fire exactly TMO cycles after RTS entry.
        d0 = n_done;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        w = 0;
        while (!(kb_data_oe && !kb_clk_oe) && w < 500) begin
            @(negedge clk);
            w++;
        end
        rts_cyc = cyc;
        chk("timeout_rts_reached", 32'(w < 500), 32'd1);
        repeat (100) @(negedge clk);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rts_valid_ignored_clk", 32'(kb_clk_oe), 32'd0);
        chk("rts_valid_ignored_data", 32'(kb_data_oe), 32'd1);
        w = 0;
        while (!tx_err && w < 1500) begin
            @(negedge clk);
            w++;
        end
        err_at = cyc;
        $display("timeout frame 3C err_after=%0d cycles", err_at - rts_cyc);
        chk("timeout_latency", 32'(err_at - rts_cyc), 32'(TMO));
        chk("timeout_lines", {30'd0, kb_clk_oe, kb_data_oe}, 32'd0);
        chk("timeout_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        chk("timeout_err_width", 32'(tx_err), 32'd0);
        repeat (100) @(negedge clk);
        chk("timeout_no_queued_send", 32'(kb_clk_oe), 32'd0);
        chk("timeout_no_done", 32'(n_done - d0), 32'd0);

        // Reset after fall 4 of a frame, then a clean 0xFF.
        do_frame(8'h5A, 1'b1, 4, bits, inh_len, rts_ok);
        chk("partial_bits", 32'(bits[3:0]), 32'hA);
        d0 = n_done;
        e0 = n_err;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_lines", {30'd0, kb_clk_oe, kb_data_oe}, 32'd0);
        chk("midreset_ready", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("midreset_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        $display("reset after fall 4 of frame 5A lines=%0d%0d ready=%0d",
                 kb_clk_oe, kb_data_oe, tx_ready);

        d0 = n_done;
        e0 = n_err;
        do_frame(8'hFF, 1'b1, 11, bits, inh_len, rts_ok);
        repeat (10) @(negedge clk);
        $display("frame FF after reset bits=%03h done=%0d err=%0d", bits, n_done - d0, n_err - e0);
        chk("post_reset_bits", 32'(bits), 32'h3FF);
        chk("post_reset_done", 32'(n_done - d0), 32'd1);
        chk("post_reset_err", 32'(n_err - e0), 32'd0);
        chk("pulse_ready_same_cycle", 32'(n_ready_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
